// File: rtl/cfg_chain_pkg.sv
// cfg_chain_pkg: state encoding and width helpers shared by the config chain loader.
package cfg_chain_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} cfg_state_e;
    function automatic int cfg_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    localparam int CHAIN_LEN_DEF = 64;
    localparam int WORD_W_DEF = 8;
    localparam int TOT_W = cfg_w(CHAIN_LEN_DEF + 1);
    localparam int BIT_W = cfg_w(WORD_W_DEF + 1);
endpackage

// File: rtl/cfg_chain_loader_if.sv
// cfg_chain_loader_if: control, word-source and chain-side signals of the loader.
interface cfg_chain_loader_if #(
    parameter int WORD_W = 8,
    parameter int DIV_W = 4
);
    logic start;
    logic abort;
    logic [DIV_W-1:0] div;
    logic s_valid;
    logic [WORD_W-1:0] s_data;
    logic s_ready;
    logic shift_en;
    logic shift_data;
    logic busy;
    logic done;
    modport master (
        output start, abort, div, s_valid, s_data,
        input s_ready, shift_en, shift_data, busy, done
    );
    modport slave (
        input start, abort, div, s_valid, s_data,
        output s_ready, shift_en, shift_data, busy, done
    );
endinterface

// File: rtl/cfg_pace_tick.sv
// cfg_pace_tick: pace counter that ticks when it reaches div_q, then restarts from zero.
module cfg_pace_tick #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div_q,
    output logic             tick
);
    logic [DIV_W-1:0] pace_q, pace_d;
    assign tick = pace_q == div_q;
    always_comb pace_d = (clr || (en && tick)) ? '0 : en ? pace_q + DIV_W'(1) : pace_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pace_q <= '0;
        else pace_q <= pace_d;
    end
endmodule

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serialises handshaked words MSB-first into a CHAIN_LEN-bit config chain.
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int DIV_W = 4
) (
    input logic clk,
    input logic reset_n,
    cfg_chain_loader_if.slave bus
);
    localparam int CNT_W = cfg_w(CHAIN_LEN + 1);
    localparam int LEFT_W = cfg_w(WORD_W + 1);
    cfg_state_e state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
    logic [LEFT_W-1:0] bits_left_q, bits_left_d;
    logic [WORD_W-1:0] wbuf_q, wbuf_d;
    logic pace_clr, tick;
    cfg_pace_tick #(.DIV_W(DIV_W)) u_pace (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (pace_clr),
        .en      (state_q == SHIFT),
        .div_q   (div_q),
        .tick    (tick)
    );
    always_comb begin
        state_d = state_q;
        div_d = div_q;
        total_cnt_d = total_cnt_q;
        bits_left_d = bits_left_q;
        wbuf_d = wbuf_q;
        pace_clr = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            total_cnt_d = '0;
            bits_left_d = '0;
            wbuf_d = '0;
            pace_clr = 1'b1;
        end else if ((state_q == IDLE || state_q == DONE) && bus.start) begin
            state_d = LOAD;
            div_d = bus.div;
            total_cnt_d = '0;
            pace_clr = 1'b1;
        end else if (state_q == LOAD && bus.s_valid) begin
            state_d = SHIFT;
            wbuf_d = bus.s_data;
            bits_left_d = LEFT_W'(WORD_W);
            pace_clr = 1'b1;
        end else if (state_q == SHIFT && tick) begin
            wbuf_d = wbuf_q << 1;
            bits_left_d = bits_left_q - LEFT_W'(1);
            total_cnt_d = total_cnt_q + CNT_W'(1);
            // The chain length check wins, so a partly used last word is dropped.
            state_d = (total_cnt_q == CNT_W'(CHAIN_LEN - 1)) ? DONE :
                      (bits_left_q == LEFT_W'(1)) ? LOAD : SHIFT;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q <= '0;
            total_cnt_q <= '0;
            bits_left_q <= '0;
            wbuf_q <= '0;
        end else begin
            state_q <= state_d;
            div_q <= div_d;
            total_cnt_q <= total_cnt_d;
            bits_left_q <= bits_left_d;
            wbuf_q <= wbuf_d;
        end
    end
    assign bus.busy = state_q == LOAD || state_q == SHIFT;
    assign bus.s_ready = state_q == LOAD;
    assign bus.done = state_q == DONE;
    assign bus.shift_en = state_q == SHIFT && tick;
    assign bus.shift_data = wbuf_q[WORD_W-1];
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: scoreboard bench driving a 16-bit and a 12-bit chain loader in turn.
module tb_cfg_chain_loader;
    logic clk = 1'b0, reset_n = 1'b0, sel = 1'b0;
    logic start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [3:0] div = '0;
    logic [7:0] s_data = '0;
    logic s_ready, shift_en, shift_data, busy, done;
    int checks = 0, errors = 0;
    logic [7:0] word_q[$];
    bit exp_q[$];
    int cyc = 0, pulses = 0, accepts = 0, acc_cyc = 0, last_cyc = 0, exp_div = 0, chain_len = 16, ready_empty = 0;
    bit first_in_word = 1'b0, expect_done = 1'b0;
    logic [15:0] chain = '0;
    logic [7:0] pend = '0;

    cfg_chain_loader_if #(.WORD_W(8), .DIV_W(4)) if16 ();
    cfg_chain_loader_if #(.WORD_W(8), .DIV_W(4)) if12 ();
    assign if16.start = start & ~sel;
    assign if12.start = start & sel;
    assign if16.abort = abort;
    assign if12.abort = abort;
    assign if16.div = div;
    assign if12.div = div;
    assign if16.s_valid = s_valid;
    assign if12.s_valid = s_valid;
    assign if16.s_data = s_data;
    assign if12.s_data = s_data;
    assign s_ready = sel ? if12.s_ready : if16.s_ready;
    assign shift_en = sel ? if12.shift_en : if16.shift_en;
    assign shift_data = sel ? if12.shift_data : if16.shift_data;
    assign busy = sel ? if12.busy : if16.busy;
    assign done = sel ? if12.done : if16.done;

    cfg_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .DIV_W(4)) u16 (.clk(clk), .reset_n(reset_n), .bus(if16.slave));
    cfg_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .DIV_W(4)) u12 (.clk(clk), .reset_n(reset_n), .bus(if12.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, advance the word source after the rising edge.
    task automatic tick();
        bit acc;
        @(negedge clk);
        cyc++;
        if (expect_done) begin
            chk("done_after_last", done, 1);
            chk("busy_after_last", busy, 0);
            expect_done = 1'b0;
        end
        if (s_ready && word_q.size() == 0) ready_empty++;
        acc = s_valid && s_ready;
        if (shift_en) begin
            if (exp_q.size() == 0) chk("pulse_count", pulses + 1, chain_len);
            else begin
                chk("shift_data", shift_data, exp_q.pop_front());
                chk("pace", cyc, first_in_word ? acc_cyc + 1 + exp_div : last_cyc + exp_div + 1);
                if (exp_q.size() == 0) expect_done = 1'b1;
            end
            chain = {chain[14:0], shift_data};
            pulses++;
            last_cyc = cyc;
            first_in_word = 1'b0;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            void'(word_q.pop_front());
            accepts++;
            acc_cyc = cyc;
            first_in_word = 1'b1;
        end
        s_valid = word_q.size() > 0;
        s_data = (word_q.size() > 0) ? word_q[0] : 8'h00;
    endtask

    task automatic begin_seq(input logic [7:0] w0, input logic [7:0] w1, input logic [3:0] d, input bit short, input bit hold);
        sel = short;
        chain_len = short ? 12 : 16;
        word_q.delete();
        exp_q.delete();
        word_q.push_back(w0);
        if (!hold) word_q.push_back(w1);
        pend = w1;
        for (int i = 0; i < chain_len; i++) exp_q.push_back(i < 8 ? w0[7-i] : w1[15-i]);
        pulses = 0;
        accepts = 0;
        ready_empty = 0;
        chain = '0;
        exp_div = d;
        first_in_word = 1'b0;
        expect_done = 1'b0;
        s_valid = 1'b1;
        s_data = w0;
        div = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && !done; i++) tick();
        chk("done_seen", done, 1);
        tick();
        chk("pulses", pulses, chain_len);
        chk("accepts", accepts, (chain_len + 7) / 8);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_shift_data", shift_data, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        begin_seq(8'hA5, 8'h3C, 4'd0, 1'b0, 1'b0);
        wait_done();
        chk("chain_div0", chain, 16'hA53C);
        chk("no_extra_req", ready_empty, 0);
        repeat (2) tick();
        chk("done_held", done, 1);
        chk("busy_in_done", busy, 0);
        begin_seq(8'hA5, 8'h3C, 4'd2, 1'b0, 1'b0);
        repeat (6) tick();
        start = 1'b1;
        div = 4'd7;
        tick();
        start = 1'b0;
        wait_done();
        chk("chain_div2", chain, 16'hA53C);
        begin_seq(8'hFF, 8'h5A, 4'd0, 1'b1, 1'b0);
        wait_done();
        chk("chain_len12", chain[11:0], 12'hFF5);
        chk("no_third_req", ready_empty, 0);
        begin_seq(8'hA5, 8'h3C, 4'd1, 1'b0, 1'b1);
        for (int i = 0; i < 200 && !(s_ready && word_q.size() == 0 && pulses == 8); i++) tick();
        chk("bp_reach", s_ready, 1);
        repeat (5) begin
            tick();
            chk("bp_ready", s_ready, 1);
            chk("bp_pulses", pulses, 8);
        end
        word_q.push_back(pend);
        s_valid = 1'b1;
        s_data = pend;
        wait_done();
        chk("chain_bp", chain, 16'hA53C);
        begin_seq(8'hA5, 8'h3C, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 200 && pulses < 5; i++) tick();
        abort = 1'b1;
        word_q.delete();
        exp_q.delete();
        s_valid = 1'b0;
        tick();
        abort = 1'b0;
        tick();
        chk("abort_shift_en", shift_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (3) tick();
        chk("abort_pulses", pulses, 5);
        begin_seq(8'hA5, 8'h3C, 4'd0, 1'b0, 1'b0);
        wait_done();
        chk("chain_after_abort", chain, 16'hA53C);
        begin_seq(8'hA5, 8'h3C, 4'd0, 1'b0, 1'b0);
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_shift_en", shift_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s_ready", s_ready, 0);
        chk("arst_done", done, 0);
        chk("arst_shift_data", shift_data, 0);
        word_q.delete();
        exp_q.delete();
        s_valid = 1'b0;
        expect_done = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
Sequencer that fills a serial configuration chain, i.e. one or more cascaded lock-after-N shift registers, from a word-wide source.
- Accepts WORD_W-bit words over a valid/ready handshake.
- Serialises each word MSB-first onto shift_en/shift_data, at a programmable pace.
- Stops after exactly CHAIN_LEN bits and reports done.
- Sits between the config source (host bridge or ROM walker) and the chain's enable/data_in pins.

Parameters:
CHAIN_LEN, 64, total bits to shift into the chain (>=1)
WORD_W, 8, width of input words (>=1)
DIV_W, 4, width of pace divider

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  pulse; begin a load sequence (ignored while busy)
abort  in  1  pulse; cancel any sequence in progress
div  in  DIV_W  pace: one shift every div+1 cycles, sampled on accepted start
s_valid  in  1  input word valid
s_data  in  WORD_W  input word
s_ready  out  1  word accepted when s_valid && s_ready
shift_en  out  1  chain shift strobe (drives chain enable)
shift_data  out  1  serial bit (drives chain data_in), meaningful only when shift_en=1
busy  out  1  sequence in progress
done  out  1  exactly CHAIN_LEN bits shifted; held until next accepted start or abort

Behaviour:
- Reset values:
  - state IDLE; s_ready, shift_en, busy, done all 0; shift_data 0.
  - All counters and buffers are 0.
- Reset is asynchronous. Asserting reset mid-sequence returns the block to IDLE immediately; no partial resume.
- States: IDLE, LOAD, SHIFT, DONE. All outputs are decoded from registers only; there is no combinational input-to-output path.
  - busy = (LOAD | SHIFT).
  - s_ready = (state==LOAD).
  - done = (state==DONE).
  - shift_en = (state==SHIFT) && (pace==div_q).
  - shift_data = wbuf[WORD_W-1].
- IDLE/DONE + start:
  - Latch div into div_q; clear total_cnt and pace.
  - Next state LOAD (done drops that edge).
- LOAD + s_valid: on the edge, wbuf <= s_data, bits_left <= WORD_W, pace <= 0, next state SHIFT. With s_valid low, stay in LOAD and hold s_ready=1.
- SHIFT, pace != div_q: pace increments; no shift.
- SHIFT, pace == div_q (shift_en high this cycle):
  - wbuf <= wbuf << 1; bits_left decrements; total_cnt increments; pace <= 0.
  - If total_cnt+1 == CHAIN_LEN, go to DONE. Remaining bits of the current word are discarded; this takes priority over word-exhausted.
  - Else if bits_left == 1, go to LOAD.
- Pace timing:
  - div=0 gives shift_en every cycle in SHIFT: WORD_W back-to-back pulses, then at least one LOAD cycle gap.
  - div=k gives pulses spaced k+1 cycles, first pulse k cycles after entering SHIFT.
- abort (any state): next state IDLE; done cleared; shift_en low from the next cycle; counters cleared. abort wins over a simultaneous start.
- start while busy is ignored. start in DONE restarts the sequence.
- Widths:
  - total_cnt uses clog2(CHAIN_LEN+1) bits.
  - bits_left uses clog2(WORD_W+1) bits.
  - pace uses DIV_W bits, compared for equality, so it never wraps.
- Words needed per sequence: ceil(CHAIN_LEN/WORD_W). No word is requested after the last shift.
- Bit order: first shifted bit is the MSB of the first word. It ends at the MSB of a left-shifting chain.

Decomposition:
- Package cfg_chain_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE);
  - a clog2-based width helper;
  - the localparams TOT_W and BIT_W.
- One natural sub-module: cfg_pace_tick, a DIV_W pace counter with clear and a tick output (pace==div_q). The rest stays in one FSM module.

Test Plan:
- CHAIN_LEN=16, WORD_W=8, div=0; start, words 0xA5 then 0x3C: exactly 16 shift_en pulses with shift_data 1010_0101_0011_1100. A chain model captures 0xA53C. done=1 the cycle after the 16th pulse; busy=0.
- div=2, same words: shift_en pulses are 3 cycles apart within a word and still total 16. A div change mid-sequence has no effect.
- CHAIN_LEN=12, words 0xFF, 0x5A: 12 pulses (8x1, then 0,1,0,1). DONE is reached without a third s_ready; the low nibble 0xA is discarded.
- Backpressure: hold s_valid=0 for 5 cycles in LOAD: s_ready stays 1, shift_en stays 0, total_cnt unchanged. Then supply the word and shifting resumes.
- abort after 5 pulses: shift_en=0 from the next cycle, busy=0, done=0. A new start requests a word and delivers a full CHAIN_LEN pulses from zero.
- reset_n low mid-SHIFT: all outputs 0 asynchronously. Also, start pulsed while busy produces no restart (pulse count unchanged).
